// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, one bit per cycle.
module alu_mc #(
  parameter int unsigned RW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  output logic          o_ready,
  input  logic [3:0]    i_mode,
  input  logic [RW-1:0] i_l,
  input  logic [RW-1:0] i_r,
  input  logic          i_carry,
  output logic [RW-1:0] o_out,
  output logic [4:0]    o_flags,
  output logic          o_dz,
  output logic          o_valid
);

  localparam int unsigned CW = $clog2(RW);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_l, r_r;
  logic          r_is_div, r_hi_sel;
  logic [2*RW-1:0] r_acc;
  logic [RW-1:0] r_out;
  logic [4:0]    r_flags;
  logic          r_dz;

  logic          w_accept, w_iter_op, w_last;
  logic [RW:0]   w_add, w_sub, w_shl;
  logic [RW-1:0] w_asr;
  logic [RW-1:0] w_sc_out;
  logic          w_sc_c, w_sc_o;
  logic [RW:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic          w_div_ge;
  logic [2*RW-1:0] w_mul_next, w_div_next, w_acc_next;
  logic [RW-1:0] w_iter_res;

  // Flag vector {P, O, N, C, Z}
  function automatic logic [4:0] mk_flags(input logic [RW-1:0] v, input logic c, input logic o);
    return {^v, o, v[RW-1], c, (v == '0)};
  endfunction

  assign o_ready   = (r_state == StIdle);
  assign w_accept  = i_req && o_ready;
  assign w_iter_op = (i_mode >= 4'd10) && (i_mode <= 4'd13);
  assign w_last    = (r_cnt == CW'(RW - 1));

  // Reset in the DONE cycle abandons the result, so the pulse is suppressed
  assign o_valid = (r_state == StDone) && !i_rst;
  assign o_out   = r_out;
  assign o_flags = r_flags;
  assign o_dz    = r_dz;

  // Single-cycle datapath, evaluated on the live inputs at accept
  assign w_add = {1'b0, i_l} + {1'b0, i_r} + {{RW{1'b0}}, i_carry};
  assign w_sub = {1'b0, i_l} - {1'b0, i_r} - {{RW{1'b0}}, i_carry};
  assign w_shl = {1'b0, i_l} << i_r;
  assign w_asr = $signed(i_l) >>> i_r;

  always_comb begin
    w_sc_out = i_l;
    w_sc_c   = 1'b0;
    w_sc_o   = 1'b0;
    case (i_mode)
      4'd1: w_sc_out = i_r;
      4'd2: begin
        w_sc_out = w_add[RW-1:0];
        w_sc_c   = w_add[RW];
        w_sc_o   = (i_l[RW-1] == i_r[RW-1]) && (w_add[RW-1] != i_l[RW-1]);
      end
      4'd3: begin
        w_sc_out = w_sub[RW-1:0];
        w_sc_c   = ~w_sub[RW];
        w_sc_o   = (i_l[RW-1] != i_r[RW-1]) && (w_sub[RW-1] != i_l[RW-1]);
      end
      4'd4: w_sc_out = i_l & i_r;
      4'd5: w_sc_out = i_l | i_r;
      4'd6: w_sc_out = i_l ^ i_r;
      4'd7: begin
        w_sc_out = w_shl[RW-1:0];
        w_sc_c   = w_shl[RW];
      end
      4'd8: w_sc_out = i_l >> i_r;
      4'd9: w_sc_out = w_asr;
      default: w_sc_out = i_l;
    endcase
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right
  assign w_mul_sum  = {1'b0, r_acc[2*RW-1:RW]} + (r_acc[0] ? {1'b0, r_l} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[RW-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; a zero divisor always
  // subtracts, which naturally yields all-ones quotient and remainder = dividend
  assign w_div_shift = {r_acc[2*RW-1:RW], r_acc[RW-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_r});
  assign w_div_diff  = w_div_shift - {1'b0, r_r};
  assign w_div_next  = w_div_ge ? {w_div_diff[RW-1:0], r_acc[RW-2:0], 1'b1}
                                : {w_div_shift[RW-1:0], r_acc[RW-2:0], 1'b0};

  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;
  assign w_iter_res = r_hi_sel ? w_acc_next[2*RW-1:RW] : w_acc_next[RW-1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = w_iter_op ? StIter : StDone;
      StIter:  if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_l      <= '0;
      r_r      <= '0;
      r_is_div <= 1'b0;
      r_hi_sel <= 1'b0;
      r_acc    <= '0;
      r_out    <= '0;
      r_flags  <= '0;
      r_dz     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_l      <= i_l;
        r_r      <= i_r;
        r_is_div <= i_mode[2];
        r_hi_sel <= i_mode[0];
        r_cnt    <= '0;
        r_acc    <= i_mode[2] ? {{RW{1'b0}}, i_l} : {{RW{1'b0}}, i_r};
        if (!w_iter_op) begin
          r_out   <= w_sc_out;
          r_flags <= mk_flags(w_sc_out, w_sc_c, w_sc_o);
          r_dz    <= 1'b0;
        end
      end
      if (r_state == StIter) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_out   <= w_iter_res;
          r_flags <= mk_flags(w_iter_res, 1'b0, 1'b0);
          r_dz    <= r_is_div && (r_r == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 16-bit and an 8-bit instance, directed vectors.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16 = 1'b1, req16 = 1'b0, c16 = 1'b0;
  logic [3:0]  mode16 = '0;
  logic [15:0] l16 = '0, r16 = '0;
  logic        ready16, dz16, valid16;
  logic [15:0] out16;
  logic [4:0]  flags16;

  logic        rst8 = 1'b1, req8 = 1'b0, c8 = 1'b0;
  logic [3:0]  mode8 = '0;
  logic [7:0]  l8 = '0, r8 = '0;
  logic        ready8, dz8, valid8;
  logic [7:0]  out8;
  logic [4:0]  flags8;

  alu_mc #(.RW(16)) dut16 (
    .i_clk(clk), .i_rst(rst16), .i_req(req16), .o_ready(ready16), .i_mode(mode16),
    .i_l(l16), .i_r(r16), .i_carry(c16), .o_out(out16), .o_flags(flags16),
    .o_dz(dz16), .o_valid(valid16)
  );

  alu_mc #(.RW(8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_req(req8), .o_ready(ready8), .i_mode(mode8),
    .i_l(l8), .i_r(r8), .i_carry(c8), .o_out(out8), .o_flags(flags8),
    .o_dz(dz8), .o_valid(valid8)
  );

  typedef struct {
    logic [31:0] out;
    logic [4:0]  flags;
    logic        dz;
    int          cyc;
    int          id;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid16) begin
      tests++;
      if (q16.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid16: got valid at cyc %0d, want none", cyc);
      end else begin
        exp_t e;
        e = q16.pop_front();
        if (out16 !== e.out[15:0] || flags16 !== e.flags || dz16 !== e.dz || cyc != e.cyc) begin
          fails++;
          $display("FAIL result16 id=%0d: got out=%h flags=%b dz=%b cyc=%0d, want out=%h flags=%b dz=%b cyc=%0d",
                   e.id, out16, flags16, dz16, cyc, e.out[15:0], e.flags, e.dz, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid8) begin
      tests++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid8: got valid at cyc %0d, want none", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if (out8 !== e.out[7:0] || flags8 !== e.flags || dz8 !== e.dz || cyc != e.cyc) begin
          fails++;
          $display("FAIL result8 id=%0d: got out=%h flags=%b dz=%b cyc=%0d, want out=%h flags=%b dz=%b cyc=%0d",
                   e.id, out8, flags8, dz8, cyc, e.out[7:0], e.flags, e.dz, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drain(input bit is16);
    int n = 0;
    while (((is16 && q16.size() != 0) || (!is16 && q8.size() != 0)) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if ((is16 && q16.size() != 0) || (!is16 && q8.size() != 0)) begin
      tests++;
      fails++;
      $display("FAIL timeout%0d: got no o_valid within 60 cycles, want a result", is16 ? 16 : 8);
      if (is16) q16.delete(); else q8.delete();
    end
  endtask

  task automatic issue16(input logic [3:0] m, input logic [15:0] l, input logic [15:0] r,
                         input logic c, input logic [15:0] eo, input logic [4:0] ef,
                         input logic ed, input int lat, input int id);
    exp_t e;
    @(negedge clk); #1;
    chk("ready16_idle", 32'(ready16), 32'd1);
    req16 = 1'b1; mode16 = m; l16 = l; r16 = r; c16 = c;
    e.out = {16'h0, eo}; e.flags = ef; e.dz = ed; e.cyc = cyc + lat; e.id = id;
    q16.push_back(e);
    @(negedge clk); #1;
    req16 = 1'b0; l16 = 16'($urandom); r16 = 16'($urandom); c16 = 1'b1;
    drain(1'b1);
  endtask

  task automatic issue8(input logic [3:0] m, input logic [7:0] l, input logic [7:0] r,
                        input logic c, input logic [7:0] eo, input logic [4:0] ef,
                        input logic ed, input int lat, input int id);
    exp_t e;
    @(negedge clk); #1;
    chk("ready8_idle", 32'(ready8), 32'd1);
    req8 = 1'b1; mode8 = m; l8 = l; r8 = r; c8 = c;
    e.out = {24'h0, eo}; e.flags = ef; e.dz = ed; e.cyc = cyc + lat; e.id = id;
    q8.push_back(e);
    @(negedge clk); #1;
    req8 = 1'b0; l8 = 8'($urandom); r8 = 8'($urandom);
    drain(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100us");
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    #1;
    chk("rst16_ready", 32'(ready16), 32'd1);
    chk("rst16_valid", 32'(valid16), 32'd0);
    chk("rst16_out",   32'(out16),   32'd0);
    chk("rst16_flags", 32'(flags16), 32'd0);
    chk("rst16_dz",    32'(dz16),    32'd0);
    chk("rst8_ready",  32'(ready8),  32'd1);
    chk("rst8_out",    32'(out8),    32'd0);
    rst16 = 1'b0; rst8 = 1'b0;

    // mode, l, r, carry, out, flags {P,O,N,C,Z}, dz, latency, id
    issue16(4'd2,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b00011, 1'b0, 1,  1);
    issue16(4'd3,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b11010, 1'b0, 1,  2);
    issue16(4'd2,  16'h7FFF, 16'h0000, 1'b1, 16'h8000, 5'b11100, 1'b0, 1,  3);
    issue16(4'd3,  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 5'b00100, 1'b0, 1,  4);
    issue16(4'd10, 16'h1234, 16'h0100, 1'b0, 16'h3400, 5'b10000, 1'b0, 17, 5);
    issue16(4'd11, 16'h1234, 16'h0100, 1'b0, 16'h0012, 5'b00000, 1'b0, 17, 6);
    issue16(4'd12, 16'd100,  16'd7,    1'b0, 16'h000E, 5'b10000, 1'b0, 17, 7);
    issue16(4'd13, 16'd100,  16'd7,    1'b0, 16'h0002, 5'b10000, 1'b0, 17, 8);
    issue16(4'd12, 16'd5,    16'd0,    1'b0, 16'hFFFF, 5'b00100, 1'b1, 17, 9);
    issue16(4'd13, 16'd5,    16'd0,    1'b0, 16'h0005, 5'b00000, 1'b1, 17, 10);
    issue16(4'd4,  16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 5'b00000, 1'b0, 1,  11);
    issue16(4'd5,  16'hF000, 16'h000F, 1'b0, 16'hF00F, 5'b00100, 1'b0, 1,  12);
    issue16(4'd6,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 5'b00001, 1'b0, 1,  13);
    issue16(4'd0,  16'h0001, 16'hFFFF, 1'b0, 16'h0001, 5'b10000, 1'b0, 1,  14);
    issue16(4'd1,  16'h0001, 16'h8000, 1'b0, 16'h8000, 5'b10100, 1'b0, 1,  15);
    issue16(4'd15, 16'h0003, 16'h1234, 1'b1, 16'h0003, 5'b00000, 1'b0, 1,  16);
    issue16(4'd7,  16'h0001, 16'd16,   1'b0, 16'h0000, 5'b00011, 1'b0, 1,  17);
    issue16(4'd7,  16'h0001, 16'd17,   1'b0, 16'h0000, 5'b00001, 1'b0, 1,  18);
    issue16(4'd8,  16'h8000, 16'd15,   1'b0, 16'h0001, 5'b10000, 1'b0, 1,  19);
    issue16(4'd8,  16'h8000, 16'd16,   1'b0, 16'h0000, 5'b00001, 1'b0, 1,  20);
    issue16(4'd9,  16'h8000, 16'd20,   1'b0, 16'hFFFF, 5'b00100, 1'b0, 1,  21);

    // Reset in ITER cycle 5 of a DIVU; then req together with reset in IDLE
    @(negedge clk); #1;
    req16 = 1'b1; mode16 = 4'd12; l16 = 16'd100; r16 = 16'd7;
    @(negedge clk); #1;
    req16 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst16 = 1'b1;
    @(negedge clk); #1;
    chk("abort_ready", 32'(ready16), 32'd1);
    chk("abort_valid", 32'(valid16), 32'd0);
    chk("abort_out",   32'(out16),   32'd0);
    chk("abort_flags", 32'(flags16), 32'd0);
    req16 = 1'b1; mode16 = 4'd2; l16 = 16'd1; r16 = 16'd1;
    @(negedge clk); #1;
    chk("req_in_rst_ready", 32'(ready16), 32'd1);
    chk("req_in_rst_out",   32'(out16),   32'd0);
    rst16 = 1'b0; req16 = 1'b0;
    repeat (20) @(negedge clk);
    issue16(4'd2, 16'h0002, 16'h0003, 1'b0, 16'h0005, 5'b00000, 1'b0, 1, 22);

    issue8(4'd9,  8'h80, 8'd9,  1'b0, 8'hFF, 5'b00100, 1'b0, 1, 31);
    issue8(4'd7,  8'h81, 8'd1,  1'b0, 8'h02, 5'b10010, 1'b0, 1, 32);
    issue8(4'd12, 8'hC8, 8'h0A, 1'b0, 8'h14, 5'b00000, 1'b0, 9, 33);

    // MUL with i_req held high and operands scrambled during ITER
    @(negedge clk); #1;
    req8 = 1'b1; mode8 = 4'd10; l8 = 8'h0F; r8 = 8'h11;
    e.out = 32'h0000_00FF; e.flags = 5'b00100; e.dz = 1'b0; e.cyc = cyc + 9; e.id = 34;
    q8.push_back(e);
    repeat (9) begin
      @(negedge clk); #1;
      l8 = 8'($urandom); r8 = 8'($urandom);
      if (q8.size() != 0 && cyc == e.cyc - 5) chk("hold_ready8", 32'(ready8), 32'd0);
    end
    req8 = 1'b0;
    drain(1'b0);
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
